// File: rtl/key_expansion_seq_if.sv
// Key-load handshake and round-key read port of the iterative AES-128 key expander.
// Latency: pure wiring, no state.
// Backpressure: key_valid/key_ready handshake; the requester holds key_valid until key_ready.
//   master (requester): drives key_valid, key_in, flush, rd_idx; observes key_ready, busy, keys_valid, rd_key
//   slave  (expander) : the mirror image
interface key_expansion_seq_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         flush;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output key_valid, key_in, flush, rd_idx,
        input  key_ready, busy, keys_valid, rd_key
    );

    modport slave (
        input  key_valid, key_in, flush, rd_idx,
        output key_ready, busy, keys_valid, rd_key
    );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key expander: one round key per clock into an 11-entry buffer.
// Latency: key accepted at edge N -> keys_valid after edge N+10; rd_key is combinational.
// Backpressure: key_ready low while expanding or flushing; keys offered meanwhile wait.
//   Ports: clk, rst_n (async active-low), bus (key_expansion_seq_if.slave).
//   Optional macro KEYEXP_KEY_CACHE_EN: a key equal to the stored one in READY is not re-expanded.

// One AES-128 key-schedule step: next round key from previous key and rcon word.
// Latency: combinational.
// Backpressure: none.
module key_schedule (
    input  logic [127:0] key_prev,
    input  logic [31:0]  rcon_word,
    output logic [127:0] key_next
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub;
    logic [31:0] w4, w5, w6, w7;

    assign {w0, w1, w2, w3} = key_prev;

    // RotWord then SubWord on the last word, mixed with the round constant
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};

    assign w4 = w0 ^ sub ^ rcon_word;
    assign w5 = w4 ^ w1;
    assign w6 = w5 ^ w2;
    assign w7 = w6 ^ w3;

    assign key_next = {w4, w5, w6, w7};
endmodule

module key_expansion_seq #(
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    key_expansion_seq_if.slave bus
);
    generate
        if (NR != 10) begin : g_nr_check
            $error("key_expansion_seq supports AES-128 only (NR must be 10)");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    logic [1:0]   state;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [127:0] rk [0:NR];

    logic [127:0] rk_prev;
    logic [127:0] rk_next;
    logic [7:0]   rcon_next;
    logic         accept;
    logic         cache_hit;

    // round is always >= 1 while expanding, so round-1 stays in range when it matters
    assign rk_prev = rk[round - 4'd1];

    key_schedule u_key_schedule (
        .key_prev  (rk_prev),
        .rcon_word ({rcon, 24'h0}),
        .key_next  (rk_next)
    );

    // xtime in GF(2^8): 01 02 04 ... 80 1b 36
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    assign bus.key_ready  = (state != ST_EXPAND) && !bus.flush;
    assign bus.busy       = (state == ST_EXPAND);
    assign bus.keys_valid = (state == ST_READY);
    assign accept         = bus.key_valid && bus.key_ready;

`ifdef KEYEXP_KEY_CACHE_EN
    // rk[0] is the cipher key itself, so a match means the buffer already holds its schedule
    assign cache_hit = (state == ST_READY) && (bus.key_in == rk[0]);
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            round <= 4'd0;
            rcon  <= 8'h01;
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else if (bus.flush) begin
            // stored keys are kept but hidden by leaving READY
            state <= ST_IDLE;
            round <= 4'd0;
        end else if (accept) begin
            if (!cache_hit) begin
                rk[0] <= bus.key_in;
                round <= 4'd1;
                rcon  <= 8'h01;
                state <= ST_EXPAND;
            end
        end else if (state == ST_EXPAND) begin
            rk[round] <= rk_next;
            rcon      <= rcon_next;
            round     <= round + 4'd1;
            if (round == 4'(NR)) begin
                state <= ST_READY;
            end
        end
    end

    // Read port is gated by READY so partial or flushed schedules never leak out
    always_comb begin
        bus.rd_key = '0;
        if (state == ST_READY && bus.rd_idx <= 4'(NR)) begin
            bus.rd_key = rk[bus.rd_idx];
        end
    end
endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: known-answer table, multi-cycle corner sequences,
// and random keys checked against a word-level FIPS-197 key expansion model.
// Latency/backpressure: exercises the 10-cycle expansion and key_ready stalls.
module tb_key_expansion_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_expansion_seq_if bus();

    key_expansion_seq #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sb  [256];
    logic [127:0] mrk [11];

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] r, b;
        for (int x = 0; x < 256; x++) begin
            r = 8'h01;
            for (int k = 0; k < 254; k++) r = gmul(r, 8'(x));
            b = (x == 0) ? 8'h00 : r;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Offers a key for one edge, then counts edges until keys_valid (bounded)
    task automatic load_key(input logic [127:0] key, output int lat, output int nb, output int both);
        bus.key_in    = key;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        lat = 0; nb = 0; both = 0;
        while (!bus.keys_valid && lat < 30) begin
            if (bus.busy) nb++;
            if (bus.busy && bus.keys_valid) both = 1;
            tick();
            lat++;
        end
    endtask

    task automatic check_all_vs_model(input string tag);
        for (int r = 0; r < 11; r++) begin
            bus.rd_idx = 4'(r);
            #1;
            chk128($sformatf("%s_rk%0d", tag, r), bus.rd_key, mrk[r]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vtab [6];
        logic [127:0] loaded;
        logic [127:0] rkey;
        int           lat, nb, both;
        logic         have;

        vtab[0] = '{K1, 4'd0,  K1};
        vtab[1] = '{K1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vtab[2] = '{K1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vtab[3] = '{K1, 4'd12, 128'h0};
        vtab[4] = '{K2, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vtab[5] = '{K2, 4'd0,  K2};

        build_sbox();

        rst_n = 1'b0; bus.key_valid = 1'b0; bus.key_in = '0; bus.flush = 1'b0; bus.rd_idx = 4'd10;
        #12;
        chk_int("rst_busy", int'(bus.busy), 0);
        chk_int("rst_keys_valid", int'(bus.keys_valid), 0);
        chk128("rst_rd_key", bus.rd_key, 128'h0);
        rst_n = 1'b1;
        tick();
        chk_int("rst_key_ready", int'(bus.key_ready), 1);

        // Known-answer table; first load also checks latency and busy length
        have = 1'b0; loaded = '0;
        for (int i = 0; i < 6; i++) begin
            if (!have || vtab[i].key != loaded) begin
                load_key(vtab[i].key, lat, nb, both);
                chk_int($sformatf("tab%0d_latency", i), lat, 10);
                chk_int($sformatf("tab%0d_busy_cycles", i), nb, 10);
                chk_int($sformatf("tab%0d_busy_kv_excl", i), both, 0);
                loaded = vtab[i].key; have = 1'b1;
            end
            bus.rd_idx = vtab[i].idx;
            #1;
            chk128($sformatf("tab%0d_rd_idx%0d", i, vtab[i].idx), bus.rd_key, vtab[i].exp);
        end

        // Key offered during EXPAND cycle 3 must wait for READY
        bus.key_in = K1; bus.key_valid = 1'b1;
        tick();
        chk_int("obusy_accept_busy", int'(bus.busy), 1);
        bus.key_valid = 1'b0;
        tick(); tick();
        bus.key_in = K2; bus.key_valid = 1'b1; bus.rd_idx = 4'd0;
        #1;
        chk_int("obusy_key_ready_low", int'(bus.key_ready), 0);
        chk128("obusy_rd_in_expand", bus.rd_key, 128'h0);
        lat = 2;
        while (!bus.keys_valid && lat < 30) begin tick(); lat++; end
        chk_int("obusy_no_restart", lat, 10);
        chk_int("obusy_ready_high", int'(bus.key_ready), 1);
        tick();
        chk_int("obusy_second_busy", int'(bus.busy), 1);
        chk_int("obusy_second_kv", int'(bus.keys_valid), 0);
        bus.key_valid = 1'b0;
        lat = 0;
        while (!bus.keys_valid && lat < 30) begin tick(); lat++; end
        chk_int("obusy_second_latency", lat, 10);
        bus.rd_idx = 4'd10;
        #1;
        chk128("obusy_k2_rk10", bus.rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Flush at EXPAND cycle 5 together with key_valid
        bus.key_in = K1; bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick(); tick(); tick(); tick();
        bus.flush = 1'b1; bus.key_valid = 1'b1; bus.key_in = K2;
        #1;
        chk_int("flush_key_ready_low", int'(bus.key_ready), 0);
        tick();
        bus.flush = 1'b0; bus.key_valid = 1'b0;
        chk_int("flush_busy", int'(bus.busy), 0);
        chk_int("flush_kv", int'(bus.keys_valid), 0);
        for (int r = 0; r < 16; r++) begin
            bus.rd_idx = 4'(r);
            #1;
            chk128($sformatf("flush_rd%0d", r), bus.rd_key, 128'h0);
        end
        tick(); tick(); tick();
        chk_int("flush_not_accepted", int'(bus.busy), 0);

        // From IDLE: FIPS key against model, out-of-range indices in READY
        load_key(K1, lat, nb, both);
        chk_int("idle_load_latency", lat, 10);
        model_expand(K1);
        check_all_vs_model("k1");
        for (int r = 11; r < 16; r++) begin
            bus.rd_idx = 4'(r);
            #1;
            chk128($sformatf("oor_rd%0d", r), bus.rd_key, 128'h0);
        end

        // Asynchronous reset between edges in the middle of an expansion
        bus.key_in = K2; bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk_int("arst_busy", int'(bus.busy), 0);
        chk_int("arst_kv", int'(bus.keys_valid), 0);
        bus.rd_idx = 4'd0;
        #1;
        chk128("arst_rd0", bus.rd_key, 128'h0);
        #1 rst_n = 1'b1;
        tick();
        chk_int("arst_key_ready", int'(bus.key_ready), 1);
        rkey = {$urandom, $urandom, $urandom, $urandom};
        load_key(rkey, lat, nb, both);
        chk_int("arst_reload_latency", lat, 10);
        model_expand(rkey);
        check_all_vs_model("arst");

        // Re-offer identical key in READY
        load_key(K1, lat, nb, both);
        model_expand(K1);
        bus.key_in = K1; bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
`ifdef KEYEXP_KEY_CACHE_EN
        chk_int("cache_kv_held", int'(bus.keys_valid), 1);
        chk_int("cache_busy_low", int'(bus.busy), 0);
        tick(); tick();
        chk_int("cache_kv_still", int'(bus.keys_valid), 1);
`else
        chk_int("recache_kv_drop", int'(bus.keys_valid), 0);
        chk_int("recache_busy", int'(bus.busy), 1);
        lat = 0;
        while (!bus.keys_valid && lat < 30) begin tick(); lat++; end
        chk_int("recache_latency", lat, 10);
`endif
        check_all_vs_model("same");

        // Random keys against the model
        for (int n = 0; n < 12; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            load_key(rkey, lat, nb, both);
            chk_int($sformatf("rnd%0d_latency", n), lat, 10);
            chk_int($sformatf("rnd%0d_busy_kv_excl", n), both, 0);
            model_expand(rkey);
            check_all_vs_model($sformatf("rnd%0d", n));
            bus.rd_idx = 4'($urandom_range(11, 15));
            #1;
            chk128($sformatf("rnd%0d_oor", n), bus.rd_key, 128'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
- Iterative AES-128 round-key generator for area-constrained cipher cores.
- Holds one `key_schedule` instance and produces one round key per clock.
- Stores all 11 round keys in an internal buffer and serves them to the round datapath through an indexed combinational read port.
- Sequences the schedule with a state machine and a generated rcon. It replaces the fully unrolled expansion where area matters more than single-cycle expansion.

Parameters:
- NR, 10, number of expansion rounds (AES-128 only). Other values are unsupported; the instance is checked at elaboration.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_valid  input  1  cipher key offered on key_in
- key_ready  output  1  block can accept a key this cycle
- key_in  input  128  cipher key; [127:120] is key byte 0, w0 = key_in[127:96]
- flush  input  1  synchronous invalidate of stored keys and any expansion in flight
- busy  output  1  expansion in progress
- keys_valid  output  1  all 11 round keys stored and readable
- rd_idx  input  4  round-key index 0..10
- rd_key  output  128  round key rd_idx, combinational

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; round counter = 0; rcon register = 8'h01.
  - All 11 key registers = 0.
  - busy = 0, keys_valid = 0, key_ready = 1 once rst_n is high.
- States:
  - IDLE: no valid keys.
  - EXPAND: generating keys.
  - READY: keys valid.
- key_ready = (state != EXPAND) && !flush. A key is accepted on a rising edge where key_valid && key_ready.
- Accept, from IDLE or READY:
  - rk[0] <= key_in; round <= 1; rcon <= 8'h01.
  - Next state EXPAND; keys_valid <= 0; busy <= 1.
- EXPAND, each cycle:
  - rk[round] <= key_schedule(rk[round-1], {rcon, 24'h0}).
  - rcon <= xtime(rcon): shift left 1; XOR with 8'h1b if bit 7 was set. Sequence is 01 02 04 08 10 20 40 80 1b 36.
  - round <= round + 1.
- Completion: on the edge that writes rk[10], next state is READY, keys_valid <= 1, busy <= 0.
- Latency: key accepted at edge N gives keys_valid = 1 after edge N+10. key_ready is low for exactly 10 cycles.
- key_valid in EXPAND is ignored (not accepted); the requester holds it.
- flush:
  - From any state, next state is IDLE, keys_valid <= 0, busy <= 0, round <= 0.
  - rk contents are retained but unreadable.
  - flush has priority over key_valid in the same cycle; the key is not accepted.
- Read port:
  - rd_key = rk[rd_idx] when keys_valid && rd_idx <= 10.
  - Otherwise rd_key = 128'h0, including all of EXPAND and rd_idx 11..15.
- Reset mid-EXPAND aborts immediately to the reset state. No partial keys are visible.
- busy and keys_valid are never both 1.

Optional Feature:
- Macro: KEYEXP_KEY_CACHE_EN.
- Defined:
  - In READY, an accepted key with key_in == rk[0] causes no re-expansion.
  - State stays READY, keys_valid stays 1 with no drop, busy stays 0.
  - A differing key expands normally.
- Not defined:
  - Every accepted key re-expands.
  - keys_valid drops to 0 the cycle after acceptance even for an identical key.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted at edge N:
  - busy=1 for 10 cycles; keys_valid=1 after edge N+10.
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=0 -> the key.
- Key offered while busy (cycle 3 of EXPAND): key_ready=0, not accepted; accepted on the first READY cycle. Then second key 000102030405060708090a0b0c0d0e0f -> rd_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
- flush asserted at EXPAND cycle 5 with key_valid=1 in the same cycle:
  - Next cycle IDLE, busy=0, keys_valid=0, key not accepted.
  - rd_key=0 for all rd_idx.
- rd_idx=11..15 in READY -> rd_key=0. Any rd_idx during EXPAND -> 0.
- rst_n pulsed low mid-EXPAND (asynchronous, between edges):
  - Outputs go to reset values immediately.
  - A new key after release expands correctly from rcon 01.
- Re-offer the same FIPS key in READY:
  - With KEYEXP_KEY_CACHE_EN: keys_valid stays 1, busy stays 0.
  - Without it: keys_valid drops for 10 cycles and returns with identical keys.
